filter_fir4_core: RTL and testbench
===================================

FILTER_FIR4_CORE -- requirements
Module: filter_fir4_core

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named ACLK and ARESETN.
REQ-002 Parameter DATA_WIDTH, default 16: signed sample width, in and out.
REQ-003 Parameter SHIFT, default 15: arithmetic right shift applied to the accumulator (Q1.15 coefficients).
REQ-004 ACLK  in  1  rising-edge clock.
REQ-005 ARESETN  in  1  asynchronous active-low reset.
REQ-006 cfg_ctrl  in  32  control register: bit0 enable, bit1 clear; other bits ignored.
REQ-007 cfg_coef01  in  32  coefficients: c0=[15:0], c1=[31:16], signed.
REQ-008 cfg_coef23  in  32  coefficients: c2=[15:0], c3=[31:16], signed.
REQ-009 cfg_status  out  32  status: [15:0] output beat count, [16] saturation sticky, [17] busy, [31:18] zero.
REQ-010 s_axis_tdata/tvalid/tlast  in  DATA_WIDTH/1/1  input sample stream.
REQ-011 s_axis_tready  out  1  input accept.
REQ-012 m_axis_tdata/tvalid/tlast  out  DATA_WIDTH/1/1  filtered output stream.
REQ-013 m_axis_tready  in  1  output accept.

Function
REQ-014 Output SHALL be y[n] = sat(( c0*x[n] + c1*x[n-1] + c2*x[n-2] + c3*x[n-3] ) >>> SHIFT), where products are full-width signed, the sum is 2*DATA_WIDTH+2 bits, and sat clamps to signed DATA_WIDTH range.
REQ-015 The datapath SHALL have two register stages: S1 (delay-line update + four products), S2 (sum, shift, saturate -> m_axis registers).
REQ-016 advance = !m_axis_tvalid || m_axis_tready; all stages SHALL move only when advance=1, otherwise hold.
REQ-017 s_axis_tready = enable && !clear && advance (combinational).
REQ-018 A sample accepted in cycle N with advance held high SHALL appear on m_axis in cycle N+2.
REQ-019 The delay line SHALL shift only on an accepted input beat, so there are no bubbles in history.
REQ-020 tlast SHALL travel with its sample through both stages, unmodified.
REQ-021 Shadow coefficients SHALL load from cfg_coef01/23 every cycle while enable=0 and freeze while enable=1; mid-run cfg changes take effect only after re-enable.
REQ-022 Enable falling SHALL block new input but let in-flight samples drain normally.
REQ-023 While clear=1: delay line forced to zero, saturation sticky cleared, beat count cleared, input blocked; in-flight S1/S2 data still drains.
REQ-024 The beat count SHALL increment on each m_axis transfer (tvalid && tready), 16-bit, wrapping 0xFFFF -> 0x0000.
REQ-025 The saturation sticky SHALL set when a value clamped in S2 is transferred on m_axis; it is cleared only by clear or reset.
REQ-026 busy SHALL equal S1 valid OR m_axis_tvalid.
REQ-027 m_axis_tdata SHALL be stable while m_axis_tvalid && !m_axis_tready (AXI-Stream rule); no beat may be lost or duplicated under backpressure.

Reset
REQ-028 While ARESETN=0 asynchronously: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, S1 valid=0, delay line=0, shadow coefficients=0, cfg_status=0; s_axis_tready=0.
REQ-029 Reset asserted mid-stream SHALL discard all in-flight samples; the first output after release comes only from new input.

Verification
REQ-030 Impulse: coef01=0x2000_4000, coef23=0x0800_1000, enable, inputs 0x4000,0,0,0, m_tready=1 -> outputs 0x2000,0x1000,0x0800,0x0400, first output 2 cycles after first accept, count=4.
REQ-031 Saturation: all coefs 0x7FFF, inputs 0x7FFF x4 -> outputs 0x7FFE,0x7FFF,0x7FFF,0x7FFF, status[16]=1; a following clear pulse -> status[16]=0, count=0.
REQ-032 Backpressure: stream 1..8 with m_tready low for 5 cycles mid-stream -> s_axis_tready low during the stall, outputs in order, none lost, tdata stable while stalled; tlast on input 8 appears on output 8 only.
REQ-033 Coefficient freeze: change coef01 while enabled -> outputs unaffected; disable, re-enable -> new coefficients used.
REQ-034 Reset mid-stream: assert ARESETN=0 with 2 samples in flight -> m_axis_tvalid=0 immediately, cfg_status=0, no stale output after release.
REQ-035 Wrap: 65536 transfers -> count reads 0x0000, then 0x0001 after the next transfer.

Source files
------------

// File: rtl/filter_fir4_core.sv
// filter_fir4_core: 4-tap signed FIR on an AXI-Stream sample path.
// Two register stages (products, then sum/shift/saturate) share one
// advance condition. The coefficients are shadowed while the filter is enabled.
module filter_fir4_core #(
    parameter int DATA_WIDTH = 16,
    parameter int SHIFT      = 15
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic [31:0]           cfg_ctrl,
    input  logic [31:0]           cfg_coef01,
    input  logic [31:0]           cfg_coef23,
    output logic [31:0]           cfg_status,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready
);

    localparam int CW = 16;              // coefficient width
    localparam int PW = DATA_WIDTH + CW; // full product width
    localparam int SW = PW + 2;          // accumulator width (4-term sum)

    localparam logic signed [SW-1:0] MAX_V =
        $signed({{(SW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}});
    localparam logic signed [SW-1:0] MIN_V =
        $signed({{(SW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}});

    logic enable;
    logic clear;
    logic advance;
    logic accept;
    logic xfer;
    logic ctrl_unused;

    logic [3:0][CW-1:0]         coef_q, coef_d;
    logic [2:0][DATA_WIDTH-1:0] hist_q, hist_d;
    logic [3:0][PW-1:0]         prod_q, prod_d;
    logic                       s1_valid_q, s1_valid_d;
    logic                       s1_last_q, s1_last_d;
    logic [DATA_WIDTH-1:0]      m_data_q, m_data_d;
    logic                       m_valid_q, m_valid_d;
    logic                       m_last_q, m_last_d;
    logic                       m_sat_q, m_sat_d;
    logic [15:0]                count_q, count_d;
    logic                       sticky_q, sticky_d;

    logic signed [SW-1:0]       sum;
    logic signed [SW-1:0]       shifted;
    logic [DATA_WIDTH-1:0]      sat_val;
    logic                       clamped;

    assign enable      = cfg_ctrl[0];
    assign clear       = cfg_ctrl[1];
    assign ctrl_unused = ^cfg_ctrl[31:2];
    assign advance     = !m_valid_q || m_axis_tready;
    // Gated with ARESETN so no beat is offered as accepted while the core is held in reset.
    assign s_axis_tready = ARESETN && enable && !clear && advance;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign xfer          = m_valid_q && m_axis_tready;

    assign m_axis_tdata  = m_data_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tlast  = m_last_q;
    assign cfg_status    = {14'b0, (s1_valid_q || m_valid_q), sticky_q, count_q};

    // S2 arithmetic: sign-extended sum of products, arithmetic shift, clamp.
    always_comb begin
        sum = SW'($signed(prod_q[0])) + SW'($signed(prod_q[1]))
            + SW'($signed(prod_q[2])) + SW'($signed(prod_q[3]));
        shifted = sum >>> SHIFT;
        clamped = 1'b0;
        sat_val = shifted[DATA_WIDTH-1:0];
        if (shifted > MAX_V) begin
            sat_val = MAX_V[DATA_WIDTH-1:0];
            clamped = 1'b1;
        end else if (shifted < MIN_V) begin
            sat_val = MIN_V[DATA_WIDTH-1:0];
            clamped = 1'b1;
        end
    end

    // Next-state for coefficients, delay line, both pipeline stages and status.
    always_comb begin
        coef_d     = coef_q;
        hist_d     = hist_q;
        prod_d     = prod_q;
        s1_valid_d = s1_valid_q;
        s1_last_d  = s1_last_q;
        m_data_d   = m_data_q;
        m_valid_d  = m_valid_q;
        m_last_d   = m_last_q;
        m_sat_d    = m_sat_q;
        count_d    = count_q;
        sticky_d   = sticky_q;

        if (!enable) begin
            coef_d = {cfg_coef23, cfg_coef01};
        end

        // clear never coincides with accept because it blocks s_axis_tready.
        if (clear) begin
            hist_d = '0;
        end else if (accept) begin
            hist_d = {hist_q[1], hist_q[0], s_axis_tdata};
        end

        if (advance) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_last_d = s_axis_tlast;
                prod_d[0] = PW'($signed(s_axis_tdata) * $signed(coef_q[0]));
                prod_d[1] = PW'($signed(hist_q[0]) * $signed(coef_q[1]));
                prod_d[2] = PW'($signed(hist_q[1]) * $signed(coef_q[2]));
                prod_d[3] = PW'($signed(hist_q[2]) * $signed(coef_q[3]));
            end
            m_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                m_data_d = sat_val;
                m_last_d = s1_last_q;
                m_sat_d  = clamped;
            end
        end

        if (clear) begin
            count_d  = '0;
            sticky_d = 1'b0;
        end else if (xfer) begin
            count_d = count_q + 16'd1;
            if (m_sat_q) begin
                sticky_d = 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            coef_q     <= '0;
            hist_q     <= '0;
            prod_q     <= '0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            m_sat_q    <= 1'b0;
            count_q    <= '0;
            sticky_q   <= 1'b0;
        end else begin
            coef_q     <= coef_d;
            hist_q     <= hist_d;
            prod_q     <= prod_d;
            s1_valid_q <= s1_valid_d;
            s1_last_q  <= s1_last_d;
            m_data_q   <= m_data_d;
            m_valid_q  <= m_valid_d;
            m_last_q   <= m_last_d;
            m_sat_q    <= m_sat_d;
            count_q    <= count_d;
            sticky_q   <= sticky_d;
        end
    end

endmodule

// File: tb/tb_filter_fir4_core.sv
// Scoreboard bench for filter_fir4_core: directed vectors push expected beats,
// a negedge monitor pops and compares every m_axis transfer.
module tb_filter_fir4_core;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [31:0] cfg_ctrl = 32'h1;
    logic [31:0] cfg_coef01 = '0;
    logic [31:0] cfg_coef23 = '0;
    logic [31:0] cfg_status;
    logic [15:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_tready;
    logic [15:0] m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc_cyc = 0;
    int first_out_cyc = -1;
    int acc0;

    logic [16:0] exp_q[$];
    logic [16:0] mon_e;
    logic [16:0] held;
    logic        stall_prev = 1'b0;

    filter_fir4_core #(.DATA_WIDTH(16), .SHIFT(15)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .cfg_ctrl(cfg_ctrl), .cfg_coef01(cfg_coef01), .cfg_coef23(cfg_coef23),
        .cfg_status(cfg_status),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
        .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
        .m_axis_tready(m_tready)
    );

    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc++;

    // Monitor: compare each transfer with the scoreboard, and check hold under stall.
    always @(negedge ACLK) begin
        if (!ARESETN) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (!m_tvalid || {m_tlast, m_tdata} !== held) begin
                    errors++;
                    $display("FAIL hold_stable got v=%b %h expected v=1 %h", m_tvalid, {m_tlast, m_tdata}, held);
                end
            end
            stall_prev = m_tvalid && !m_tready;
            held = {m_tlast, m_tdata};
            if (m_tvalid && m_tready) begin
                checks++;
                if (first_out_cyc < 0) first_out_cyc = cyc;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat got %h expected none", {m_tlast, m_tdata});
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({m_tlast, m_tdata} !== mon_e) begin
                        errors++;
                        $display("FAIL beat got last/data %h expected %h", {m_tlast, m_tdata}, mon_e);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // Entered and left at posedge+1.
    task automatic send(input logic [15:0] x, input logic last);
        int n = 0;
        s_tdata  = x;
        s_tlast  = last;
        s_tvalid = 1'b1;
        @(negedge ACLK);
        while (!s_tready && n < 200) begin
            @(negedge ACLK);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got tready=0 expected tready=1");
        end else begin
            last_acc_cyc = cyc;
        end
        @(posedge ACLK);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        @(negedge ACLK);
        while (!(exp_q.size() == 0 && cfg_status[17] == 1'b0) && n < 200) begin
            @(negedge ACLK);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got pending=%0d expected 0", exp_q.size());
        end
        @(posedge ACLK);
        #1;
    endtask

    task automatic setup(input logic [31:0] c01, input logic [31:0] c23);
        cfg_ctrl   = 32'h0;
        cfg_coef01 = c01;
        cfg_coef23 = c23;
        repeat (2) @(posedge ACLK);
        #1 cfg_ctrl = 32'h2;
        @(posedge ACLK);
        #1 cfg_ctrl = 32'h1;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state (enable already high, tready must still be 0).
        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_m_tvalid", {31'b0, m_tvalid}, 32'h0);
        chk("rst_m_tdata", {16'b0, m_tdata}, 32'h0);
        chk("rst_m_tlast", {31'b0, m_tlast}, 32'h0);
        chk("rst_status", cfg_status, 32'h0);
        chk("rst_s_tready", {31'b0, s_tready}, 32'h0);
        ARESETN = 1'b1;
        @(posedge ACLK);
        #1;

        // Impulse response.
        setup(32'h2000_4000, 32'h0800_1000);
        exp_q.push_back({1'b0, 16'h2000});
        exp_q.push_back({1'b0, 16'h1000});
        exp_q.push_back({1'b0, 16'h0800});
        exp_q.push_back({1'b0, 16'h0400});
        first_out_cyc = -1;
        send(16'h4000, 1'b0);
        acc0 = last_acc_cyc;
        chk("busy_inflight", {31'b0, cfg_status[17]}, 32'h1);
        send(16'h0000, 1'b0);
        send(16'h0000, 1'b0);
        send(16'h0000, 1'b0);
        wait_drain();
        chk("impulse_latency", first_out_cyc - acc0, 32'd2);
        chk("impulse_status", cfg_status, 32'h0000_0004);

        // Saturation and sticky clear.
        setup(32'h7FFF_7FFF, 32'h7FFF_7FFF);
        exp_q.push_back({1'b0, 16'h7FFE});
        repeat (3) exp_q.push_back({1'b0, 16'h7FFF});
        repeat (4) send(16'h7FFF, 1'b0);
        wait_drain();
        chk("sat_status", cfg_status, 32'h0001_0004);
        cfg_ctrl = 32'h3;
        @(posedge ACLK);
        #1 cfg_ctrl = 32'h1;
        chk("clear_status", cfg_status, 32'h0);

        // Backpressure: x = 0x100*k, y = x/2 + x[n-1]/4, tlast on k=8.
        setup(32'h2000_4000, 32'h0);
        exp_q.push_back({1'b0, 16'h0080});
        exp_q.push_back({1'b0, 16'h0140});
        exp_q.push_back({1'b0, 16'h0200});
        exp_q.push_back({1'b0, 16'h02C0});
        exp_q.push_back({1'b0, 16'h0380});
        exp_q.push_back({1'b0, 16'h0440});
        exp_q.push_back({1'b0, 16'h0500});
        exp_q.push_back({1'b1, 16'h05C0});
        fork
            begin
                for (int k = 1; k <= 8; k++) send(16'(k * 256), k == 8);
            end
            begin
                repeat (4) @(posedge ACLK);
                #1 m_tready = 1'b0;
                repeat (5) begin
                    @(negedge ACLK);
                    chk("stall_s_tready", {31'b0, s_tready}, 32'h0);
                end
                @(posedge ACLK);
                #1 m_tready = 1'b1;
            end
        join
        wait_drain();
        chk("bp_count", cfg_status, 32'h0000_0008);

        // Coefficient freeze while enabled, reload after re-enable.
        setup(32'h0000_4000, 32'h0);
        exp_q.push_back({1'b0, 16'h0800});
        send(16'h1000, 1'b0);
        cfg_coef01 = 32'h0000_2000;
        exp_q.push_back({1'b0, 16'h0800});
        send(16'h1000, 1'b0);
        wait_drain();
        cfg_ctrl = 32'h0;
        repeat (2) @(posedge ACLK);
        #1 cfg_ctrl = 32'h1;
        exp_q.push_back({1'b0, 16'h0400});
        send(16'h1000, 1'b0);
        wait_drain();

        // Reset with two samples in flight: nothing pushed, nothing may emerge.
        send(16'h1000, 1'b0);
        send(16'h1000, 1'b0);
        ARESETN = 1'b0;
        #1;
        chk("midrst_m_tvalid", {31'b0, m_tvalid}, 32'h0);
        chk("midrst_status", cfg_status, 32'h0);
        chk("midrst_s_tready", {31'b0, s_tready}, 32'h0);
        repeat (2) @(posedge ACLK);
        #1 ARESETN = 1'b1;
        repeat (3) @(negedge ACLK);
        chk("post_rst_idle", {31'b0, m_tvalid}, 32'h0);
        @(posedge ACLK);
        #1;
        setup(32'h0000_4000, 32'h0);
        exp_q.push_back({1'b0, 16'h0300});
        send(16'h0600, 1'b0);
        wait_drain();
        chk("post_rst_count", cfg_status, 32'h0000_0001);

        // Beat count wrap.
        setup(32'h0, 32'h0);
        for (int i = 0; i < 65536; i++) begin
            exp_q.push_back({1'b0, 16'h0000});
            send(16'(i), 1'b0);
        end
        wait_drain();
        chk("wrap_zero", {16'b0, cfg_status[15:0]}, 32'h0);
        exp_q.push_back({1'b0, 16'h0000});
        send(16'h1234, 1'b0);
        wait_drain();
        chk("wrap_one", {16'b0, cfg_status[15:0]}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
